// File: rtl/icc_mailbox_hub_pkg.sv
// Shared defaults and message-entry layout for the inter-core mailbox hub.
// The multicore top uses the core-ID enum to address mailboxes by name.
package icc_mailbox_hub_pkg;
  localparam int MBOX_NCORES = 4;
  localparam int MBOX_ID_W   = 2;
  localparam int MBOX_DATA_W = 14;
  localparam int MBOX_DEPTH  = 4;

  typedef enum logic [1:0] {CORE0 = 2'd0, CORE1 = 2'd1, CORE2 = 2'd2, CORE3 = 2'd3} core_id_e;

  // FIFO entry is {src, data}; data sits in the low bits
  localparam int ENT_DATA_LSB = 0;
  function automatic int ent_src_lsb(input int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/icc_mailbox_hub_if.sv
// Send/receive bundle between the cores (master) and the mailbox hub (slave).
interface icc_mailbox_hub_if
  import icc_mailbox_hub_pkg::*;
#(
  parameter int NCORES = MBOX_NCORES,
  parameter int ID_W   = MBOX_ID_W,
  parameter int DATA_W = MBOX_DATA_W,
  parameter int PTR_W  = $clog2(MBOX_DEPTH)
);
  logic [NCORES-1:0]             tx_valid;
  logic [NCORES-1:0][ID_W-1:0]   tx_dest;
  logic [NCORES-1:0][DATA_W-1:0] tx_data;
  logic [NCORES-1:0]             tx_ready;
  logic [NCORES-1:0]             rx_valid;
  logic [NCORES-1:0][ID_W-1:0]   rx_src;
  logic [NCORES-1:0][DATA_W-1:0] rx_data;
  logic [NCORES-1:0]             rx_ack;
  logic [NCORES-1:0][PTR_W:0]    rx_count;
  logic [NCORES-1:0]             err_sticky;

  modport master (
    output tx_valid, tx_dest, tx_data, rx_ack,
    input  tx_ready, rx_valid, rx_src, rx_data, rx_count, err_sticky
  );
  modport slave (
    input  tx_valid, tx_dest, tx_data, rx_ack,
    output tx_ready, rx_valid, rx_src, rx_data, rx_count, err_sticky
  );
endinterface

// File: rtl/icc_mailbox_hub_fifo.sv
// Single-destination mailbox FIFO: storage, wrap-around pointers, occupancy.
// Head output reads as zero while empty.
module icc_mailbox_hub_fifo
  import icc_mailbox_hub_pkg::*;
#(
  parameter int W     = MBOX_ID_W + MBOX_DATA_W,
  parameter int DEPTH = MBOX_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           gclk,
  input  logic           grst_n,
  input  logic           wr_en_i,
  input  logic [W-1:0]   wr_data_i,
  input  logic           rd_en_i,
  output logic [W-1:0]   rd_data_o,
  output logic           valid_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o
);
  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W:0]          cnt_q, cnt_d;
  logic                    push, pop;

  assign push = wr_en_i && (cnt_q != FULL_CNT);
  assign pop  = rd_en_i && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = wr_data_i;
      wp_d        = wp_q + PTR_W'(1);
    end
    if (pop) rp_d = rp_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o   = (cnt_q != '0);
  assign rd_data_o = valid_o ? mem_q[rp_q] : '0;
  assign count_o   = cnt_q;
  assign full_o    = (cnt_q == FULL_CNT);
endmodule

// File: rtl/icc_mailbox_hub.sv
// Star of per-destination mailbox FIFOs with round-robin arbitration among senders.
// Sends to an out-of-range destination are swallowed and flagged per source.
module icc_mailbox_hub
  import icc_mailbox_hub_pkg::*;
#(
  parameter int NCORES = MBOX_NCORES,
  parameter int ID_W   = MBOX_ID_W,
  parameter int DATA_W = MBOX_DATA_W,
  parameter int DEPTH  = MBOX_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic             Clock_pin,
  input  logic             Resetn_pin,
  icc_mailbox_hub_if.slave mb
);
  localparam int ENT_W   = ID_W + DATA_W;
  localparam int SRC_LSB = ent_src_lsb(DATA_W);

  logic [NCORES-1:0]             bad_dest, wr_en, full, rdy;
  logic [NCORES-1:0]             err_q, err_d;
  logic [NCORES-1:0][ID_W-1:0]   gnt_id, rr_ptr_q, rr_ptr_d;
  logic [NCORES-1:0][ENT_W-1:0]  wr_ent, rd_ent;
  logic [NCORES-1:0]             rx_vld;
  logic [NCORES-1:0][ID_W-1:0]   rx_src_w;
  logic [NCORES-1:0][DATA_W-1:0] rx_data_w;
  logic [NCORES-1:0][PTR_W:0]    rx_cnt;

  always_comb begin
    bad_dest = '0;
    for (int i = 0; i < NCORES; i++)
      bad_dest[i] = mb.tx_valid[i] && (32'(mb.tx_dest[i]) >= NCORES);
  end

  for (genvar d = 0; d < NCORES; d++) begin : g_dst
    logic [NCORES-1:0] req;
    logic              gv;
    logic [ID_W-1:0]   gi;
    int                idx;

    always_comb begin
      req = '0;
      for (int i = 0; i < NCORES; i++)
        req[i] = mb.tx_valid[i] && (mb.tx_dest[i] == ID_W'(d));
    end

    // first requester at or after rr_ptr, wrapping at NCORES
    always_comb begin
      gv  = 1'b0;
      gi  = '0;
      idx = 0;
      for (int k = 0; k < NCORES; k++) begin
        idx = int'(rr_ptr_q[d]) + k;
        if (idx >= NCORES) idx = idx - NCORES;
        if (!gv && req[idx]) begin
          gv = 1'b1;
          gi = ID_W'(idx);
        end
      end
    end

    // full check uses registered count only, so a same-cycle pop never frees a slot
    assign gnt_id[d]   = gi;
    assign wr_en[d]    = gv && !full[d] && Resetn_pin;
    assign wr_ent[d]   = {gi, mb.tx_data[gi]};
    assign rr_ptr_d[d] = !wr_en[d] ? rr_ptr_q[d] :
                         (gi == ID_W'(NCORES - 1)) ? '0 : gi + ID_W'(1);

    icc_mailbox_hub_fifo #(.W(ENT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .gclk      (Clock_pin),
      .grst_n    (Resetn_pin),
      .wr_en_i   (wr_en[d]),
      .wr_data_i (wr_ent[d]),
      .rd_en_i   (mb.rx_ack[d]),
      .rd_data_o (rd_ent[d]),
      .valid_o   (rx_vld[d]),
      .count_o   (rx_cnt[d]),
      .full_o    (full[d])
    );

    assign rx_src_w[d]  = rd_ent[d][SRC_LSB +: ID_W];
    assign rx_data_w[d] = rd_ent[d][ENT_DATA_LSB +: DATA_W];
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < NCORES; i++) begin
      for (int d = 0; d < NCORES; d++)
        if (wr_en[d] && (gnt_id[d] == ID_W'(i))) rdy[i] = 1'b1;
      if (bad_dest[i]) rdy[i] = 1'b1;
    end
    if (!Resetn_pin) rdy = '0;
  end

  assign err_d = err_q | bad_dest;

  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      rr_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign mb.tx_ready   = rdy;
  assign mb.rx_valid   = rx_vld;
  assign mb.rx_src     = rx_src_w;
  assign mb.rx_data    = rx_data_w;
  assign mb.rx_count   = rx_cnt;
  assign mb.err_sticky = err_q;
endmodule

// File: tb/tb_icc_mailbox_hub.sv
// Scoreboard bench for the mailbox hub: a 4-core instance for traffic and a
// 3-core instance for the out-of-range destination case.
module tb_icc_mailbox_hub;
  import icc_mailbox_hub_pkg::*;

  localparam int N = 4, IW = 2, DW = 14, DEPTH = 4, PW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  icc_mailbox_hub_if #(.NCORES(N), .ID_W(IW), .DATA_W(DW), .PTR_W(PW)) mb4();
  icc_mailbox_hub_if #(.NCORES(3), .ID_W(IW), .DATA_W(DW), .PTR_W(PW)) mb3();

  icc_mailbox_hub #(.NCORES(N), .ID_W(IW), .DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .Clock_pin(clk), .Resetn_pin(rst_n), .mb(mb4));
  icc_mailbox_hub #(.NCORES(3), .ID_W(IW), .DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut3 (
    .Clock_pin(clk), .Resetn_pin(rst_n), .mb(mb3));

  int n_chk  = 0;
  int n_fail = 0;
  logic [IW+DW-1:0] sbq [N][$];
  logic [DW-1:0]    dsrc [N];
  int               gord [4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // settle, log accepts/pops into the scoreboard, then advance one clock
  task automatic tick();
    #1;
    for (int i = 0; i < N; i++)
      if (rst_n && mb4.tx_valid[i] && mb4.tx_ready[i])
        sbq[mb4.tx_dest[i]].push_back({IW'(i), mb4.tx_data[i]});
    for (int d = 0; d < N; d++)
      if (mb4.rx_valid[d] && mb4.rx_ack[d]) begin
        if (sbq[d].size() == 0) chk("sb_underflow", 32'(sbq[d].size()), 32'd1);
        else chk("sb_pop", 32'({mb4.rx_src[d], mb4.rx_data[d]}), 32'(sbq[d].pop_front()));
      end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    gord = '{1, 2, 3, 1};
    mb4.tx_valid = '0; mb4.tx_dest = '0; mb4.tx_data = '0; mb4.rx_ack = '0;
    mb3.tx_valid = '0; mb3.tx_dest = '0; mb3.tx_data = '0; mb3.rx_ack = '0;

    // reset: outputs quiet, tx_ready gated even with live requests
    #1 rst_n = 1'b0;
    mb4.tx_valid[0] = 1'b1; mb4.tx_dest[0] = CORE2; mb4.tx_data[0] = 14'h0ABC;
    mb3.tx_valid[1] = 1'b1; mb3.tx_dest[1] = 2'd3;
    #11;
    chk("rst_tx_ready", 32'(mb4.tx_ready), 32'h0);
    chk("rst_tx_ready3", 32'(mb3.tx_ready), 32'h0);
    chk("rst_rx_valid", 32'(mb4.rx_valid), 32'h0);
    chk("rst_rx_count", 32'(mb4.rx_count), 32'h0);
    chk("rst_rx_data", 32'(mb4.rx_data), 32'h0);
    chk("rst_err", 32'(mb4.err_sticky), 32'h0);
    mb4.tx_valid = '0; mb3.tx_valid = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // basic send core0 -> dest2
    mb4.tx_valid[0] = 1'b1; mb4.tx_dest[0] = CORE2; mb4.tx_data[0] = 14'h0ABC;
    #1 chk("basic_rdy", 32'(mb4.tx_ready), 32'h1);
    tick();
    mb4.tx_valid = '0;
    #1;
    chk("basic_vld", 32'(mb4.rx_valid[2]), 32'h1);
    chk("basic_src", 32'(mb4.rx_src[2]), 32'h0);
    chk("basic_data", 32'(mb4.rx_data[2]), 32'h0ABC);
    chk("basic_cnt", 32'(mb4.rx_count[2]), 32'h1);
    mb4.rx_ack[2] = 1'b1;
    tick();
    mb4.rx_ack = '0;
    #1;
    chk("basic_vld_after", 32'(mb4.rx_valid[2]), 32'h0);
    chk("basic_cnt_after", 32'(mb4.rx_count[2]), 32'h0);

    // contention: cores 1..3 -> dest0, expected grants 1,2,3,1 then full
    for (int i = 1; i < 4; i++) begin
      mb4.tx_valid[i] = 1'b1; mb4.tx_dest[i] = CORE0;
      dsrc[i] = DW'(14'h100 + 16 * i); mb4.tx_data[i] = dsrc[i];
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_gnt", 32'(mb4.tx_ready), 32'(1 << gord[k]));
      chk("cont_cnt", 32'(mb4.rx_count[0]), 32'(k));
      tick();
      dsrc[gord[k]] = dsrc[gord[k]] + DW'(1);
      mb4.tx_data[gord[k]] = dsrc[gord[k]];
    end
    #1;
    chk("cont_full_rdy", 32'(mb4.tx_ready), 32'h0);
    chk("cont_full_cnt", 32'(mb4.rx_count[0]), 32'd4);
    mb4.tx_valid = '0;
    mb4.rx_ack[0] = 1'b1;
    repeat (4) tick();
    mb4.rx_ack = '0;
    #1 chk("cont_drain_cnt", 32'(mb4.rx_count[0]), 32'h0);

    // full + pop on dest1: pop does not open a slot in the same cycle
    mb4.tx_valid[0] = 1'b1; mb4.tx_dest[0] = CORE1;
    for (int k = 0; k < 4; k++) begin
      mb4.tx_data[0] = DW'(14'h200 + k);
      #1 chk("fill_rdy", 32'(mb4.tx_ready[0]), 32'h1);
      tick();
    end
    mb4.tx_data[0] = 14'h204;
    #1;
    chk("full_rdy", 32'(mb4.tx_ready[0]), 32'h0);
    chk("full_cnt", 32'(mb4.rx_count[1]), 32'd4);
    mb4.rx_ack[1] = 1'b1;
    #1 chk("full_pop_rdy", 32'(mb4.tx_ready[0]), 32'h0);
    tick();
    mb4.rx_ack = '0;
    #1;
    chk("after_pop_cnt", 32'(mb4.rx_count[1]), 32'd3);
    chk("after_pop_rdy", 32'(mb4.tx_ready[0]), 32'h1);
    tick();
    mb4.tx_valid = '0;
    #1 chk("refill_cnt", 32'(mb4.rx_count[1]), 32'd4);
    mb4.rx_ack[1] = 1'b1;
    repeat (4) tick();
    mb4.rx_ack = '0;
    #1 chk("full_drain_cnt", 32'(mb4.rx_count[1]), 32'h0);

    // streaming push+pop, core3 -> dest0, pointers wrap twice
    mb4.rx_ack[0] = 1'b1;
    mb4.tx_valid[3] = 1'b1; mb4.tx_dest[3] = CORE0;
    for (int k = 0; k < 10; k++) begin
      mb4.tx_data[3] = DW'(k);
      #1;
      chk("strm_rdy", 32'(mb4.tx_ready[3]), 32'h1);
      chk("strm_cnt", 32'(mb4.rx_count[0]), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk("strm_head", 32'(mb4.rx_data[0]), 32'(k - 1));
      tick();
    end
    mb4.tx_valid = '0;
    #1 chk("strm_tail_cnt", 32'(mb4.rx_count[0]), 32'd1);
    tick();
    mb4.rx_ack = '0;
    #1;
    chk("strm_end_cnt", 32'(mb4.rx_count[0]), 32'h0);
    chk("strm_end_vld", 32'(mb4.rx_valid[0]), 32'h0);

    // out-of-range destination on the 3-core hub
    mb3.tx_valid[1] = 1'b1; mb3.tx_dest[1] = 2'd3; mb3.tx_data[1] = 14'h155;
    #1;
    chk("inv_rdy", 32'(mb3.tx_ready[1]), 32'h1);
    chk("inv_err_pre", 32'(mb3.err_sticky), 32'h0);
    tick();
    mb3.tx_valid = '0;
    #1;
    chk("inv_err", 32'(mb3.err_sticky), 32'b010);
    chk("inv_vld", 32'(mb3.rx_valid), 32'h0);
    chk("inv_cnt", 32'(mb3.rx_count), 32'h0);
    repeat (3) tick();
    #1 chk("inv_hold", 32'(mb3.err_sticky), 32'b010);

    // reset mid-cycle with two entries queued on dest1
    mb4.tx_valid[2] = 1'b1; mb4.tx_dest[2] = CORE1;
    for (int k = 0; k < 2; k++) begin
      mb4.tx_data[2] = DW'(14'h300 + k);
      tick();
    end
    mb4.tx_valid = '0;
    #1 chk("pre_rst_cnt", 32'(mb4.rx_count[1]), 32'd2);
    mb4.tx_valid[0] = 1'b1; mb4.tx_dest[0] = CORE3; mb4.tx_data[0] = 14'h3FF;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(mb4.rx_valid), 32'h0);
    chk("mid_rst_cnt", 32'(mb4.rx_count), 32'h0);
    chk("mid_rst_err3", 32'(mb3.err_sticky), 32'h0);
    chk("mid_rst_rdy", 32'(mb4.tx_ready), 32'h0);
    for (int d = 0; d < N; d++) sbq[d].delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("post_rst_rdy", 32'(mb4.tx_ready), 32'h1);
    tick();
    mb4.tx_valid = '0;
    #1;
    chk("post_rst_vld", 32'(mb4.rx_valid), 32'b1000);
    chk("post_rst_src", 32'(mb4.rx_src[3]), 32'h0);
    chk("post_rst_data", 32'(mb4.rx_data[3]), 32'h3FF);
    chk("post_rst_cnt", 32'(mb4.rx_count[3]), 32'h1);
    mb4.rx_ack[3] = 1'b1;
    tick();
    mb4.rx_ack = '0;
    #1 chk("post_rst_drain", 32'(mb4.rx_count[3]), 32'h0);

    for (int d = 0; d < N; d++) chk("sb_left", 32'(sbq[d].size()), 32'h0);
    chk("err4_clean", 32'(mb4.err_sticky), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icc_mailbox_hub.md
Name: icc_mailbox_hub

Overview:
- Parametrised inter-core message hub for N vfmRISC621 cores.
- Replaces point-to-point ack/data port wiring with a star of per-destination mailbox FIFOs.
- Any core can send a tagged word to any core; multiple senders to one destination are arbitrated round-robin.
- Instantiated once in the multicore top; each core drives one send port and one receive port through its peripheral In/Out lines.

Parameters:
- NCORES, 4, number of attached cores (2..2**ID_W).
- ID_W, 2, width of core-ID fields.
- DATA_W, 14, message payload width.
- DEPTH, 4, entries per destination FIFO; power of 2, >= 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- Clock_pin  in  1  system clock; all state on rising edge.
- Resetn_pin  in  1  asynchronous active-low reset.
- tx_valid  in  NCORES  per-source send request.
- tx_dest  in  NCORES*ID_W  per-source destination ID; slice i = source i.
- tx_data  in  NCORES*DATA_W  per-source payload.
- tx_ready  out  NCORES  per-source accept; transfer occurs when tx_valid & tx_ready.
- rx_valid  out  NCORES  per-destination head-of-FIFO valid.
- rx_src  out  NCORES*ID_W  source ID of head entry.
- rx_data  out  NCORES*DATA_W  payload of head entry.
- rx_ack  in  NCORES  per-destination pop strobe.
- rx_count  out  NCORES*(PTR_W+1)  occupancy per destination, 0..DEPTH.
- err_sticky  out  NCORES  per-source flag; set on a send to an invalid destination.

Behaviour:
- Reset (async, Resetn_pin=0): all FIFOs empty, all pointers and counts 0, all RR pointers 0, err_sticky=0.
  - Held at reset: rx_valid=0, rx_src=0, rx_data=0, tx_ready=0.
  - Reset asserted mid-transfer discards all queued messages. No partial state survives.
- Request: source i requests destination d when tx_valid[i]=1 and tx_dest_i=d<NCORES.
- Arbitration, per destination d (combinational):
  - Starting at rr_ptr[d], grant the first requesting source in ascending index with wrap-around.
  - tx_ready[i]=1 only if i holds the grant for its destination and that FIFO count < DEPTH.
  - tx_ready may depend combinationally on tx_valid/tx_dest. Senders must hold valid/dest/data stable until ready.
- RR pointer update: on an accepted write from source g into destination d, rr_ptr[d] <= (g+1) mod NCORES. Otherwise unchanged.
- Full FIFO (count==DEPTH): tx_ready=0 for all sources to that destination, even if rx_ack[d] pops in the same cycle. There is no comb path from rx_ack to tx_ready.
- Write: accepted message {src=i, data} is written at the write pointer.
  - Latency: written word visible on rx_* on the next cycle if the FIFO was empty.
- Read:
  - rx_valid[d]=(count!=0); rx_src/rx_data show the head entry and are 0 when empty.
  - rx_ack[d] with rx_valid[d]=1 advances the read pointer at the next edge.
  - rx_ack on an empty FIFO is ignored.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Self-send (dest==src) is allowed and behaves like any other send (loopback).
- Invalid destination (tx_dest_i >= NCORES, with tx_valid[i]=1):
  - tx_ready[i]=1; the message is discarded.
  - err_sticky[i] sets at the next edge and clears only on reset.
- Ordering: messages from one source to one destination are delivered in send order. There is no ordering guarantee across sources.
- Throughput: each destination accepts at most 1 message/cycle. Different destinations accept in parallel; up to NCORES transfers per cycle.

Decomposition:
- Shared header mbox_defs.vh holds:
  - default NCORES/ID_W/DATA_W/DEPTH;
  - the message-entry field offsets {src, data};
  - the core-ID constants used by the multicore top.
- Sub-module mbox_fifo: single-destination FIFO (storage, pointers, count), generated NCORES times.
- The round-robin grant logic stays in icc_mailbox_hub as a generate loop per destination.

Test Plan:
- Basic send: core0 sends data 14'h0ABC to dest 2.
  - Required: tx_ready[0]=1; next cycle rx_valid[2]=1, rx_src=0, rx_data=0ABC, rx_count[2]=1.
  - rx_ack[2] then gives rx_valid[2]=0 and count 0.
- Contention: cores 1, 2, 3 all send to dest 0 continuously, starting with rr_ptr=0.
  - Required grant order: 1, 2, 3, 1, ...
  - FIFO order holds src 1, 2, 3, 1; once count reaches 4, tx_ready to dest 0 is 0.
- Full/pop: dest 1 full (4 entries), rx_ack[1]=1 with a pending sender.
  - Required: no accept that cycle, count becomes 3.
  - Next cycle the sender is accepted; count returns to 4.
- Simultaneous push/pop and wrap:
  - Stream 10 messages (0..9) from core3 to dest 0 while acking every cycle.
  - Required: data out in order 0..9; count stays at 1 after the first; pointers wrap cleanly.
- Invalid destination: set NCORES=3 and have core1 send to dest 3.
  - Required: tx_ready[1]=1, no FIFO changes, err_sticky[1]=1 held until Resetn_pin=0.
- Reset mid-operation: assert Resetn_pin=0 asynchronously (between clock edges) with 2 entries queued.
  - Required: immediately rx_valid=0, rx_count=0, err_sticky=0.
  - After release, the first new send is delivered normally.
